addsub_arbiter: RTL and testbench

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

---
 rtl/addsub_arbiter_pkg.sv | 13 +
 rtl/addsub_arbiter_addsubers.sv | 22 ++
 rtl/addsub_arbiter.sv | 120 ++++++++++++
 tb/tb_addsub_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_arbiter_pkg.sv
// Shared definitions for the two-requester add/sub arbiter: result FSM states
// and requester identifiers.
package addsub_arbiter_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_e;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/addsub_arbiter_addsubers.sv
// LENGTH-bit add/sub unit: s = a + b' with b' = b or two's-complement of b,
// c = carry-out of that addition with carry-in 0.
module AddSubers #(
  parameter int unsigned LENGTH = 32
) (
  input  logic [LENGTH-1:0] i_a,
  input  logic [LENGTH-1:0] i_b,
  input  logic              i_sub,
  output logic [LENGTH-1:0] o_s,
  output logic              o_c
);

  logic [LENGTH-1:0] w_b_eff;
  logic [LENGTH:0]   w_sum;

  // Negation is truncated first, so subtracting zero yields b' = 0 and c = 0.
  assign w_b_eff = i_sub ? LENGTH'(~i_b + LENGTH'(1)) : i_b;
  assign w_sum   = {1'b0, i_a} + {1'b0, w_b_eff};
  assign o_s     = w_sum[LENGTH-1:0];
  assign o_c     = w_sum[LENGTH];

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one add/sub datapath between two requesters,
// with a single registered result slot and a delivered-result counter.
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int unsigned LENGTH = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [LENGTH-1:0] req0_a,
  input  logic [LENGTH-1:0] req0_b,
  input  logic              req0_sub,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [LENGTH-1:0] req1_a,
  input  logic [LENGTH-1:0] req1_b,
  input  logic              req1_sub,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [LENGTH-1:0] rsp_s,
  output logic              rsp_c,
  output logic [CNT_W-1:0]  ops_done
);

  rsp_state_e        r_state;
  rsp_state_e        w_state_nxt;
  logic              r_ptr;
  logic              r_id;
  logic [LENGTH-1:0] r_s;
  logic              r_c;
  logic [CNT_W-1:0]  r_ops;

  logic              w_grant;
  logic              w_can_accept;
  logic              w_accept;
  logic              w_deliver;
  logic [LENGTH-1:0] w_a;
  logic [LENGTH-1:0] w_b;
  logic              w_sub;
  logic [LENGTH-1:0] w_s;
  logic              w_c;

  // Round-robin grant: a lone requester wins, contention goes to r_ptr.
  always_comb begin
    w_grant = ID_REQ0;
    if (req0_valid && req1_valid) begin
      w_grant = r_ptr;
    end else if (req1_valid) begin
      w_grant = ID_REQ1;
    end
  end

  assign w_can_accept = rstn && ((r_state == ST_EMPTY) || rsp_ready);
  assign w_accept     = w_can_accept && (req0_valid || req1_valid);
  assign w_deliver    = (r_state == ST_FULL) && rsp_ready;
  assign req0_ready   = w_accept && (w_grant == ID_REQ0);
  assign req1_ready   = w_accept && (w_grant == ID_REQ1);

  assign w_a   = (w_grant == ID_REQ1) ? req1_a   : req0_a;
  assign w_b   = (w_grant == ID_REQ1) ? req1_b   : req0_b;
  assign w_sub = (w_grant == ID_REQ1) ? req1_sub : req0_sub;

  AddSubers #(
    .LENGTH (LENGTH)
  ) u_addsub (
    .i_a   (w_a),
    .i_b   (w_b),
    .i_sub (w_sub),
    .o_s   (w_s),
    .o_c   (w_c)
  );

  // Result-slot FSM next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) w_state_nxt = ST_FULL;
      end
      ST_FULL: begin
        if (w_accept)       w_state_nxt = ST_FULL;
        else if (rsp_ready) w_state_nxt = ST_EMPTY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_EMPTY;
      r_ptr   <= ID_REQ0;
      r_id    <= ID_REQ0;
      r_s     <= '0;
      r_c     <= 1'b0;
      r_ops   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_s   <= w_s;
        r_c   <= w_c;
        r_id  <= w_grant;
        r_ptr <= ~w_grant;
      end
      if (w_deliver) begin
        r_ops <= r_ops + CNT_W'(1);
      end
    end
  end

  assign rsp_valid = (r_state == ST_FULL);
  assign rsp_id    = r_id;
  assign rsp_s     = r_s;
  assign rsp_c     = r_c;
  assign ops_done  = r_ops;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Scoreboard bench for addsub_arbiter: a behavioural arbitration model predicts
// grants and results; a separate monitor checks every presented response.
module tb_addsub_arbiter;

  localparam int unsigned LENGTH = 32;
  localparam int unsigned CNT_W  = 4;

  typedef struct {
    logic              id;
    logic [LENGTH-1:0] s;
    logic              c;
  } exp_t;

  logic              clk;
  logic              rstn;
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [LENGTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic              req0_sub, req1_sub;
  logic              rsp_valid, rsp_ready, rsp_id, rsp_c;
  logic [LENGTH-1:0] rsp_s;
  logic [CNT_W-1:0]  ops_done;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];

  // Behavioural model state
  bit   m_full = 0;
  bit   m_ptr  = 0;
  int   m_ops  = 0;

  addsub_arbiter #(.LENGTH(LENGTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sub   (req1_sub),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_s      (rsp_s),
    .rsp_c      (rsp_c),
    .ops_done   (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: subtraction as addition of 2^LENGTH - b, modulo 2^LENGTH.
  function automatic exp_t ref_op(input logic id, input logic [LENGTH-1:0] a,
                                  input logic [LENGTH-1:0] b, input logic sub);
    exp_t e;
    longint unsigned bb, sum;
    bb  = sub ? ((64'h1_0000_0000 - longint'(b)) % 64'h1_0000_0000) : longint'(b);
    sum = longint'(a) + bb;
    e.id = id;
    e.s  = sum[31:0];
    e.c  = sum[32];
    return e;
  endfunction

  // One cycle: drive at negedge, check model predictions before posedge.
  task automatic step(input logic v0, input logic [LENGTH-1:0] a0, input logic [LENGTH-1:0] b0,
                      input logic s0, input logic v1, input logic [LENGTH-1:0] a1,
                      input logic [LENGTH-1:0] b1, input logic s1, input logic rr);
    bit acc, g;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_sub = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_sub = s1;
    rsp_ready  = rr;
    #2;
    acc = (!m_full || rr) && (v0 || v1);
    g   = (v0 && v1) ? m_ptr : (v1 && !v0);
    chk("rsp_valid", rsp_valid, m_full);
    chk("req0_ready", req0_ready, acc && !g);
    chk("req1_ready", req1_ready, acc && g);
    chk("ops_done", ops_done, m_ops);
    if (acc) q.push_back(g ? ref_op(1'b1, a1, b1, s1) : ref_op(1'b0, a0, b0, s0));
    if (m_full && rr) m_ops = (m_ops + 1) % (1 << CNT_W);
    if (acc) begin
      m_full = 1;
      m_ptr  = !g;
    end else if (rr) begin
      m_full = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rr);
    step(0, '0, '0, 0, 0, '0, '0, 0, rr);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
    #2;
    chk("reset req0_ready", req0_ready, 0);
    chk("reset req1_ready", req1_ready, 0);
    @(negedge clk);
    rstn = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    q.delete();
    m_full = 0; m_ptr = 0; m_ops = 0;
  endtask

  // Monitor: every presented response must match the scoreboard head.
  always @(negedge clk) begin
    #4;
    if (rstn && rsp_valid) begin
      if (q.size() == 0) begin
        chk("unexpected rsp_valid", rsp_valid, 0);
      end else begin
        chk("rsp_id", rsp_id, q[0].id);
        chk("rsp_s", rsp_s, q[0].s);
        chk("rsp_c", rsp_c, q[0].c);
        if (rsp_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LENGTH-1:0] held_s;
    logic [LENGTH-1:0] ra0, rb0, ra1, rb1;
    rstn = 1'b0; rsp_ready = 1'b0;
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_sub = 0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_sub = 0;
    @(negedge clk);
    do_reset();
    chk("post-reset rsp_valid", rsp_valid, 0);
    chk("post-reset rsp_s", rsp_s, 0);
    chk("post-reset rsp_c", rsp_c, 0);
    chk("post-reset rsp_id", rsp_id, 0);
    chk("post-reset ops_done", ops_done, 0);

    // Single add
    step(1, 5, 3, 0, 0, '0, '0, 0, 1);
    chk("add s", rsp_s, 8);
    chk("add c", rsp_c, 0);
    chk("add id", rsp_id, 0);
    idle(1);
    chk("add ops_done", ops_done, 1);

    // Subtract cases from requester 1
    step(0, '0, '0, 0, 1, 5, 3, 1, 1);
    chk("sub 5-3 s", rsp_s, 2);
    chk("sub 5-3 c", rsp_c, 1);
    chk("sub 5-3 id", rsp_id, 1);
    step(0, '0, '0, 0, 1, 3, 5, 1, 1);
    chk("sub 3-5 s", rsp_s, 32'hFFFF_FFFE);
    chk("sub 3-5 c", rsp_c, 0);
    step(0, '0, '0, 0, 1, 7, 0, 1, 1);
    chk("sub 7-0 s", rsp_s, 7);
    chk("sub 7-0 c", rsp_c, 0);
    idle(1);

    // Contention from reset: ids alternate 0,1,0,1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 32'(100 + i), 32'(i), 0, 1, 32'(200 + i), 32'(i), 1, 1);
      chk("contention id", rsp_id, i % 2);
    end
    idle(1);

    // Backpressure: result held for 5 cycles, then same-cycle accept
    step(1, 32'h1234, 32'h11, 0, 0, '0, '0, 0, 1);
    held_s = 32'h1245;
    for (int i = 0; i < 5; i++) begin
      step(1, 32'd9, 32'd1, 0, 1, 32'd9, 32'd2, 1, 0);
      chk("backpressure hold s", rsp_s, held_s);
    end
    step(1, 32'd9, 32'd1, 0, 1, 32'd9, 32'd2, 1, 1);
    idle(1);
    idle(1);

    // Reset while FULL drops the pending result and the pointer
    step(1, 32'd40, 32'd2, 0, 0, '0, '0, 0, 0);
    do_reset();
    chk("mid-reset rsp_valid", rsp_valid, 0);
    chk("mid-reset ops_done", ops_done, 0);
    step(1, 32'd1, 32'd1, 0, 1, 32'd2, 32'd2, 0, 1);
    chk("mid-reset ptr grant", rsp_id, 0);
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      ra0 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      rb0 = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
      ra1 = 32'($urandom);
      rb1 = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
      step(1'($urandom_range(0, 1)), ra0, rb0, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ra1, rb1, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0));
    end
    idle(1);
    idle(1);
    chk("scoreboard drained", 64'(q.size()), 0);

    // Counter wrap with CNT_W=4: 17 deliveries
    do_reset();
    for (int i = 0; i < 17; i++) step(1, 32'(i), 32'd1, 0, 0, '0, '0, 0, 1);
    idle(1);
    chk("ops_done wrap", ops_done, 1);
    chk("wrap scoreboard drained", 64'(q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
